// File: rtl/imm_gen_stage.sv
// RV32/RV64 immediate-generation stage: decodes format/immediate at push into a small FIFO.
// Latency: 1 cycle push to out_valid; no combinational path from inputs to head outputs.
// Backpressure: in_ready drops when DEPTH entries are held, even if out_ready is high.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [XLEN-1:0]          out_imm,
    output logic [2:0]               out_fmt,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_INV = 3'd7;

    logic [31:0]     r_mem_instr [DEPTH];
    logic [XLEN-1:0] r_mem_imm   [DEPTH];
    logic [2:0]      r_mem_fmt   [DEPTH];
    logic            r_mem_ill   [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic [2:0]      w_fmt;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic            w_ill;
    logic            w_push;
    logic            w_pop;

    always_comb begin
        w_fmt   = FMT_INV;
        w_imm32 = '0;
        w_ill   = 1'b1;
        if (in_instr[1:0] == 2'b11) begin
            case (in_instr[6:0])
                7'b0110011: begin w_fmt = FMT_R; w_ill = 1'b0; end
                7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                    w_fmt = FMT_I; w_ill = 1'b0;
                end
                7'b0100011: begin w_fmt = FMT_S; w_ill = 1'b0; end
                7'b1100011: begin w_fmt = FMT_B; w_ill = 1'b0; end
                7'b0110111, 7'b0010111: begin w_fmt = FMT_U; w_ill = 1'b0; end
                7'b1101111: begin w_fmt = FMT_J; w_ill = 1'b0; end
                // OP-IMM-32 / OP-32 exist only on RV64
                7'b0011011: if (XLEN == 64) begin w_fmt = FMT_I; w_ill = 1'b0; end
                7'b0111011: if (XLEN == 64) begin w_fmt = FMT_R; w_ill = 1'b0; end
                default: ;
            endcase
        end
        case (w_fmt)
            FMT_I: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: w_imm32 = {in_instr[31:12], 12'b0};
            FMT_J: w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign w_imm    = XLEN'($signed(w_imm32));
    assign in_ready = (r_count < FULL);
    assign out_valid = (r_count != '0);
    assign w_push   = in_valid && in_ready && !flush;
    assign w_pop    = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_mem_instr[k] <= '0;
                r_mem_imm[k]   <= '0;
                r_mem_fmt[k]   <= '0;
                r_mem_ill[k]   <= 1'b0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_instr[r_wr_ptr] <= in_instr;
                r_mem_imm[r_wr_ptr]   <= w_imm;
                r_mem_fmt[r_wr_ptr]   <= w_fmt;
                r_mem_ill[r_wr_ptr]   <= w_ill;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_instr   = r_mem_instr[r_rd_ptr];
    assign out_imm     = r_mem_imm[r_rd_ptr];
    assign out_fmt     = r_mem_fmt[r_rd_ptr];
    assign out_illegal = r_mem_ill[r_rd_ptr];
    assign count       = r_count;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench: an RV32 and an RV64 instance share the same stimulus.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_instr, a_out_imm;
    logic [2:0]  a_out_fmt;
    logic [1:0]  a_count;

    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [31:0] b_out_instr;
    logic [63:0] b_out_imm;
    logic [2:0]  b_out_fmt;
    logic [1:0]  b_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .DEPTH(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_instr(a_out_instr),
        .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal),
        .count(a_count)
    );

    imm_gen_stage #(.XLEN(64), .DEPTH(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_instr(b_out_instr),
        .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal),
        .count(b_count)
    );

    task automatic test_reset;
        rst_n = 1'b0;
        #7;
        n_vec++;
        if ({a_in_ready, a_out_valid, a_count, a_out_fmt, a_out_illegal} !== 8'b1000_0000
            || a_out_imm !== 32'h0 || a_out_instr !== 32'h0) begin
            n_err++;
            $display("FAIL reset32: rdy=%b vld=%b cnt=%0d fmt=%0d ill=%b imm=%h instr=%h, want 1 0 0 0 0 0 0",
                     a_in_ready, a_out_valid, a_count, a_out_fmt, a_out_illegal, a_out_imm, a_out_instr);
        end
        n_vec++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_count !== 2'd0 || b_out_imm !== 64'h0) begin
            n_err++;
            $display("FAIL reset64: rdy=%b vld=%b cnt=%0d imm=%h, want 1 0 0 0",
                     b_in_ready, b_out_valid, b_count, b_out_imm);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: rdy=%b vld=%b, want 1 0", a_in_ready, a_out_valid);
        end
    endtask

    task automatic test_i_format;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hAAA07083;
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (a_out_valid !== 1'b1 || a_out_fmt !== 3'd1 || a_out_imm !== 32'hFFFFFAAA
            || a_out_illegal !== 1'b0 || a_out_instr !== 32'hAAA07083) begin
            n_err++;
            $display("FAIL i_fmt32: vld=%b fmt=%0d imm=%h ill=%b instr=%h, want 1 1 fffffaaa 0 aaa07083",
                     a_out_valid, a_out_fmt, a_out_imm, a_out_illegal, a_out_instr);
        end
        n_vec++;
        if (b_out_imm !== 64'hFFFFFFFFFFFFFAAA) begin
            n_err++;
            $display("FAIL i_fmt64: imm=%h, want fffffffffffffaaa", b_out_imm);
        end
        @(negedge clk);
        n_vec++;
        if (a_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL i_drain: vld=%b, want 0", a_out_valid);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h54007AA3;
        @(negedge clk);
        in_instr = 32'hAA007563;
        n_vec++;
        if (a_out_fmt !== 3'd2 || a_out_imm !== 32'h00000555 || a_count !== 2'd1) begin
            n_err++;
            $display("FAIL s_fmt: fmt=%0d imm=%h cnt=%0d, want 2 00000555 1", a_out_fmt, a_out_imm, a_count);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (a_out_fmt !== 3'd3 || a_out_imm !== 32'hFFFFF2AA || a_count !== 2'd1) begin
            n_err++;
            $display("FAIL b_fmt: fmt=%0d imm=%h cnt=%0d, want 3 fffff2aa 1", a_out_fmt, a_out_imm, a_count);
        end
        @(negedge clk);
    endtask

    task automatic test_rv64;
        logic [31:0] words [3];
        logic [63:0] imms  [3];
        logic [2:0]  fmts  [3];
        words[0] = 32'hFFFFF0B7; imms[0] = 64'hFFFFFFFFFFFFF000; fmts[0] = 3'd4;
        words[1] = 32'h000010EF; imms[1] = 64'h0000000000001000; fmts[1] = 3'd5;
        words[2] = 32'hFE007033; imms[2] = 64'h0;                fmts[2] = 3'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_instr = words[i];
            @(negedge clk);
            n_vec++;
            if (b_out_valid !== 1'b1 || b_out_imm !== imms[i] || b_out_fmt !== fmts[i]) begin
                n_err++;
                $display("FAIL rv64_%0d: vld=%b imm=%h fmt=%0d, want 1 %h %0d",
                         i, b_out_valid, b_out_imm, b_out_fmt, imms[i], fmts[i]);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_invalid;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h0000001B;
        @(negedge clk);
        in_instr = 32'hFFF00010;
        n_vec++;
        if (a_out_fmt !== 3'd7 || a_out_illegal !== 1'b1 || a_out_imm !== 32'h0 || a_out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL op32_rv32: fmt=%0d ill=%b imm=%h vld=%b, want 7 1 0 1",
                     a_out_fmt, a_out_illegal, a_out_imm, a_out_valid);
        end
        n_vec++;
        if (b_out_fmt !== 3'd1 || b_out_illegal !== 1'b0 || b_out_imm !== 64'h0) begin
            n_err++;
            $display("FAIL op32_rv64: fmt=%0d ill=%b imm=%h, want 1 0 0", b_out_fmt, b_out_illegal, b_out_imm);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (b_out_fmt !== 3'd7 || b_out_illegal !== 1'b1 || b_out_imm !== 64'h0
            || b_out_instr !== 32'hFFF00010) begin
            n_err++;
            $display("FAIL low_bits: fmt=%0d ill=%b imm=%h instr=%h, want 7 1 0 fff00010",
                     b_out_fmt, b_out_illegal, b_out_imm, b_out_instr);
        end
        @(negedge clk);
    endtask

    task automatic test_full;
        logic [1:0]  exp_cnt [6];
        logic        exp_rdy [6];
        logic [31:0] exp_imm [6];
        // rows: after push A, push B, C held, pop A, push C + pop B, pop C
        exp_cnt[0] = 2'd1; exp_rdy[0] = 1'b1; exp_imm[0] = 32'd1;
        exp_cnt[1] = 2'd2; exp_rdy[1] = 1'b0; exp_imm[1] = 32'd1;
        exp_cnt[2] = 2'd2; exp_rdy[2] = 1'b0; exp_imm[2] = 32'd1;
        exp_cnt[3] = 2'd1; exp_rdy[3] = 1'b1; exp_imm[3] = 32'd2;
        exp_cnt[4] = 2'd1; exp_rdy[4] = 1'b1; exp_imm[4] = 32'd3;
        exp_cnt[5] = 2'd0; exp_rdy[5] = 1'b1; exp_imm[5] = 32'd3;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: in_instr = 32'h00100013;
                1: in_instr = 32'h00200013;
                2: in_instr = 32'h00300013;
                3: out_ready = 1'b1;
                5: in_valid = 1'b0;
                default: ;
            endcase
            if (i == 2) out_ready = 1'b1;
            if (i == 2) out_ready = 1'b0;
            @(negedge clk);
            n_vec++;
            if (a_count !== exp_cnt[i] || a_in_ready !== exp_rdy[i]
                || (exp_cnt[i] != 2'd0 && a_out_imm !== exp_imm[i])) begin
                n_err++;
                $display("FAIL full_step%0d: cnt=%0d rdy=%b imm=%h, want %0d %b %h",
                         i, a_count, a_in_ready, a_out_imm, exp_cnt[i], exp_rdy[i], exp_imm[i]);
            end
            if (i == 4) in_valid = 1'b0;
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100013;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (a_count !== 2'd2) begin
            n_err++;
            $display("FAIL flush_fill: cnt=%0d, want 2", a_count);
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (a_count !== 2'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || b_count !== 2'd0) begin
            n_err++;
            $display("FAIL flush: cnt=%0d vld=%b rdy=%b cnt64=%0d, want 0 0 1 0",
                     a_count, a_out_valid, a_in_ready, b_count);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hAAA07083;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (a_out_valid !== 1'b0 || a_count !== 2'd0 || a_out_imm !== 32'h0 || a_out_fmt !== 3'd0
            || a_out_instr !== 32'h0 || a_in_ready !== 1'b1 || b_out_imm !== 64'h0) begin
            n_err++;
            $display("FAIL async_reset: vld=%b cnt=%0d imm=%h fmt=%0d instr=%h rdy=%b imm64=%h, want 0 0 0 0 0 1 0",
                     a_out_valid, a_count, a_out_imm, a_out_fmt, a_out_instr, a_in_ready, b_out_imm);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (a_out_valid !== 1'b0 || a_count !== 2'd0) begin
            n_err++;
            $display("FAIL reset_release: vld=%b cnt=%0d, want 0 0", a_out_valid, a_count);
        end
    endtask

    initial begin
        test_reset();
        test_i_format();
        test_back_to_back();
        test_rv64();
        test_invalid();
        test_full();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
